tug_scorer_param: RTL and testbench
===================================

// Module: tug_scorer_param
// PURPOSE
//  Parametrised tug-of-war scorer. Tracks rope position between -SIDE_DEPTH (left) and +SIDE_DEPTH (right).
//  Moves on each decided round and detects a game win. Drives a (2*SIDE_DEPTH+1)-bit LED score word.
//  Sits after the push arbiter, which supplies winrnd/right/tie, and before the LED driver.
//  Adds over the fixed 7-LED scorer: variable depth, a selectable favour-the-loser rule,
//  new_game restart without reset, and a round counter.
// PARAMETERS
//  SIDE_DEPTH    3   positions per side; a step beyond +/-SIDE_DEPTH wins (range 1..7)
//  FAVOUR_LOSER  1   1: valid push toward centre from |pos|>=2 snaps to +/-1; 0: always single step
//  MATCH_WINS    3   games needed to take a match (used only with TUG_MATCH_EN)
//  SCORE_W (localparam) = 2*SIDE_DEPTH+1
// PORTS
//  clk          in   1        system clock; single clock domain
//  rst          in   1        synchronous, active-high reset
//  winrnd       in   1        one-cycle pulse: a round was decided
//  right        in   1        1 = right player pushed first
//  leds_on      in   1        start lights were on at the push
//  tie          in   1        round was a tie (qualifies winrnd)
//  fake         in   1        fake-play round active
//  new_game     in   1        one-cycle pulse: restart game
//  score        out  SCORE_W  LED pattern, MSB = far left
//  pos          out  4        signed rope position (two's complement)
//  game_over    out  1        high while in WIN_L/WIN_R
//  winner_right out  1        valid while game_over; 1 = right won
//  win_pulse    out  1        one cycle on entry to a WIN state
//  rounds       out  8        non-tie rounds this game, saturates at 255
//  games_l/games_r out 4      games won per side (macro only, else 0)
//  match_over   out  1        match decided (macro only, else 0)
// BEHAVIOUR
//  - Reset: state PLAY, pos=0, score=centre bit only, game_over=0, winner_right=0, win_pulse=0, rounds=0, games=0, match_over=0.
//  - All outputs are registered; the effect of winrnd is visible the cycle after the pulse.
//  - States: PLAY, WIN_L, WIN_R. A round step occurs only when winrnd & ~tie & state==PLAY.
//  - Direction: mr = (leds_on & ~fake) ? right : ~right. A jump-the-light push or any push in fake play penalises the pusher.
//  - Valid push (leds_on & ~fake) with FAVOUR_LOSER=1:
//      moving toward centre from |pos|>=2 sets pos=+/-1 (same side); otherwise pos steps by 1.
//  - Invalid/fake push: always single step.
//  - mr at pos=+SIDE_DEPTH -> WIN_R. ~mr at pos=-SIDE_DEPTH -> WIN_L. win_pulse=1 for 1 cycle; pos holds at the edge.
//  - WIN states: winrnd ignored; exited only by new_game or rst.
//  - new_game (any state, not match_over): next cycle PLAY, pos=0, rounds=0. It has priority over a same-cycle winrnd, which is dropped.
//  - tie with winrnd: no move; rounds unchanged.
//  - score: PLAY sets bit index SIDE_DEPTH-pos only.
//      WIN_L sets the top SIDE_DEPTH bits. WIN_R sets the low SIDE_DEPTH bits.
//      An illegal state shows alternating 1010.. and returns to PLAY/pos=0 next cycle.
//  - rounds increments on every step, including the winning step; it saturates at 255.
// CONFIGURATION
//  - TUG_MATCH_EN defined: games_l/games_r increment on win_pulse.
//    match_over sets when either count reaches MATCH_WINS; new_game is then ignored until rst.
//  - TUG_MATCH_EN undefined: the counters and match logic are absent; games_l, games_r and match_over are tied to 0.
// STRUCTURE
//  - tug_pkg: state codes (PLAY/WIN_L/WIN_R), the ERR_PATTERN function of width, and the pos width constant.
//  - Sub-module tug_score_decode (combinational): state+pos -> score pattern.
//    It is instantiated once; its output is registered in the parent.
// TESTING (SIDE_DEPTH=3 unless noted)
//  1. rst=1 then 0 -> score=0001000, pos=0, game_over=0, rounds=0.
//  2. 3 valid right pushes -> score 0000100, 0000010, 0000001.
//     4th push -> 0000111, win_pulse for 1 cycle, winner_right=1, rounds=4.
//  3. pos=+3, valid left push -> pos=+1 (0000100). Same stimulus with FAVOUR_LOSER=0 -> pos=+2 (0000010).
//  4. pos=0, leds_on=0, right=1 -> pos=-1 (0010000).
//     pos=0, leds_on=1, fake=1, right=0 -> pos=+1 (0000100).
//  5. winrnd with tie=1 -> pos and rounds unchanged.
//     In WIN_R, winrnd -> no change. new_game+winrnd in the same cycle -> PLAY, pos=0, rounds=0, no step.
//  6. TUG_MATCH_EN, MATCH_WINS=2: two right wins -> games_r=2, match_over=1; then new_game -> still WIN_R.

Source files
------------

// File: rtl/tug_pkg.sv
// Shared types and helpers for the tug-of-war scorer: state codes, rope position width,
// and the alternating pattern shown when the state register holds an unused code.
package tug_pkg;

  localparam int POS_W       = 4;
  localparam int SCORE_W_MAX = 15;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_WIN_L = 2'd1,
    ST_WIN_R = 2'd2
  } tug_state_e;

  // MSB-first 1010.. pattern of the given width, right-aligned in a max-width word.
  function automatic logic [SCORE_W_MAX-1:0] err_pattern(input int width);
    logic [SCORE_W_MAX-1:0] p;
    p = '0;
    for (int i = 0; i < SCORE_W_MAX; i++) begin
      if (i < width) p[i] = ((width - 1 - i) % 2 == 0);
    end
    return p;
  endfunction

endpackage

// File: rtl/tug_score_decode.sv
// Combinational LED decode: game state and rope position to the score word (MSB = far left).
module tug_score_decode
  import tug_pkg::*;
#(
  parameter  int SIDE_DEPTH = 3,
  localparam int SCORE_W    = 2*SIDE_DEPTH+1
) (
  input  tug_state_e                  state_i,
  input  logic signed [POS_W-1:0]     pos_i,
  output logic        [SCORE_W-1:0]   score_o
);

  always_comb begin
    logic [SCORE_W_MAX-1:0] err;
    int idx;
    err     = err_pattern(SCORE_W);
    idx     = SIDE_DEPTH - int'($signed(pos_i));
    score_o = '0;
    case (state_i)
      ST_PLAY: begin
        for (int i = 0; i < SCORE_W; i++) score_o[i] = (i == idx);
      end
      ST_WIN_L: begin
        for (int i = 0; i < SCORE_W; i++) score_o[i] = (i > SIDE_DEPTH);
      end
      ST_WIN_R: begin
        for (int i = 0; i < SCORE_W; i++) score_o[i] = (i < SIDE_DEPTH);
      end
      default: score_o = err[SCORE_W-1:0];
    endcase
  end

endmodule

// File: rtl/tug_scorer_param.sv
// Parametrised tug-of-war scorer with round counting and new_game restart.
// Optional match counting (games per side, match_over lock) is built when TUG_MATCH_EN is defined.
module tug_scorer_param
  import tug_pkg::*;
#(
  parameter  int SIDE_DEPTH   = 3,
  parameter  int FAVOUR_LOSER = 1,
  parameter  int MATCH_WINS   = 3,
  localparam int SCORE_W      = 2*SIDE_DEPTH+1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      winrnd,
  input  logic                      right,
  input  logic                      leds_on,
  input  logic                      tie,
  input  logic                      fake,
  input  logic                      new_game,
  output logic [SCORE_W-1:0]        score,
  output logic signed [POS_W-1:0]   pos,
  output logic                      game_over,
  output logic                      winner_right,
  output logic                      win_pulse,
  output logic [7:0]                rounds,
  output logic [3:0]                games_l,
  output logic [3:0]                games_r,
  output logic                      match_over
);

  localparam logic signed [POS_W-1:0] POS_MAX = POS_W'(SIDE_DEPTH);
  localparam logic signed [POS_W-1:0] POS_MIN = -POS_MAX;
  localparam logic signed [POS_W-1:0] POS_P1  = 4'sd1;
  localparam logic signed [POS_W-1:0] POS_M1  = -4'sd1;
  localparam logic signed [POS_W-1:0] POS_P2  = 4'sd2;
  localparam logic signed [POS_W-1:0] POS_M2  = -4'sd2;
  localparam logic [SCORE_W-1:0]      SCORE_CENTRE = SCORE_W'(1) << SIDE_DEPTH;
  localparam bit                      FAVOUR = (FAVOUR_LOSER != 0);

  tug_state_e                 state_q, state_d, dec_state;
  logic signed [POS_W-1:0]    pos_q, pos_d;
  logic [7:0]                 rounds_q, rounds_d;
  logic [SCORE_W-1:0]         score_q, score_d;
  logic                       game_over_q, winner_right_q, win_pulse_q, win_pulse_d;
  logic                       valid_push, move_right, snap, step, restart, match_lock;

  // A jumped light or any fake-play push counts against the pusher.
  assign valid_push = leds_on & ~fake;
  assign move_right = valid_push ? right : ~right;
  assign snap       = valid_push & FAVOUR;
  assign restart    = new_game & ~match_lock;
  assign step       = winrnd & ~tie & (state_q == ST_PLAY) & ~restart;

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    rounds_d    = rounds_q;
    win_pulse_d = 1'b0;
    case (state_q)
      ST_PLAY: begin
        if (step) begin
          rounds_d = (rounds_q == 8'hFF) ? rounds_q : rounds_q + 8'd1;
          if (move_right && pos_q == POS_MAX) begin
            state_d     = ST_WIN_R;
            win_pulse_d = 1'b1;
          end else if (!move_right && pos_q == POS_MIN) begin
            state_d     = ST_WIN_L;
            win_pulse_d = 1'b1;
          end else if (move_right) begin
            pos_d = (snap && pos_q <= POS_M2) ? POS_M1 : pos_q + POS_P1;
          end else begin
            pos_d = (snap && pos_q >= POS_P2) ? POS_P1 : pos_q - POS_P1;
          end
        end
      end
      ST_WIN_L, ST_WIN_R: ;
      default: begin
        state_d = ST_PLAY;
        pos_d   = '0;
      end
    endcase
    if (restart) begin
      state_d     = ST_PLAY;
      pos_d       = '0;
      rounds_d    = '0;
      win_pulse_d = 1'b0;
    end
  end

  // An unused state code is shown for one cycle while the FSM recovers to PLAY.
  assign dec_state = (state_q == ST_PLAY || state_q == ST_WIN_L || state_q == ST_WIN_R)
                     ? state_d : state_q;

  tug_score_decode #(.SIDE_DEPTH(SIDE_DEPTH)) u_decode (
    .state_i (dec_state),
    .pos_i   (pos_d),
    .score_o (score_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_PLAY;
      pos_q          <= '0;
      rounds_q       <= '0;
      score_q        <= SCORE_CENTRE;
      game_over_q    <= 1'b0;
      winner_right_q <= 1'b0;
      win_pulse_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      pos_q          <= pos_d;
      rounds_q       <= rounds_d;
      score_q        <= score_d;
      game_over_q    <= (state_d == ST_WIN_L) || (state_d == ST_WIN_R);
      winner_right_q <= (state_d == ST_WIN_R);
      win_pulse_q    <= win_pulse_d;
    end
  end

  assign score        = score_q;
  assign pos          = pos_q;
  assign game_over    = game_over_q;
  assign winner_right = winner_right_q;
  assign win_pulse    = win_pulse_q;
  assign rounds       = rounds_q;

`ifdef TUG_MATCH_EN
  logic [3:0] games_l_q, games_l_d, games_r_q, games_r_d;
  logic       match_over_q, match_over_d;

  always_comb begin
    games_l_d = games_l_q;
    games_r_d = games_r_q;
    if (win_pulse_d && state_d == ST_WIN_L && games_l_q != 4'hF) games_l_d = games_l_q + 4'd1;
    if (win_pulse_d && state_d == ST_WIN_R && games_r_q != 4'hF) games_r_d = games_r_q + 4'd1;
    match_over_d = match_over_q | (int'(games_l_d) >= MATCH_WINS) | (int'(games_r_d) >= MATCH_WINS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      games_l_q    <= '0;
      games_r_q    <= '0;
      match_over_q <= 1'b0;
    end else begin
      games_l_q    <= games_l_d;
      games_r_q    <= games_r_d;
      match_over_q <= match_over_d;
    end
  end

  assign match_lock = match_over_q;
  assign games_l    = games_l_q;
  assign games_r    = games_r_q;
  assign match_over = match_over_q;
`else
  assign match_lock = 1'b0;
  assign games_l    = '0;
  assign games_r    = '0;
  assign match_over = 1'b0;
`endif

endmodule

// File: tb/tb_tug_scorer_param.sv
// Bench for tug_scorer_param: two instances (depth 3 favour-loser, depth 5 plain step, match of 2)
// driven in lockstep and compared against a game-rule model every cycle.
module tb_tug_scorer_param;

  logic clk = 1'b0;
  logic rst, winrnd, right, leds_on, tie, fake, new_game;

  logic [6:0]         score_a;
  logic signed [3:0]  pos_a;
  logic               go_a, wr_a, wp_a, mo_a;
  logic [7:0]         rounds_a;
  logic [3:0]         gl_a, gr_a;

  logic [10:0]        score_b;
  logic signed [3:0]  pos_b;
  logic               go_b, wr_b, wp_b, mo_b;
  logic [7:0]         rounds_b;
  logic [3:0]         gl_b, gr_b;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    int st;      // 0 play, 1 left won, 2 right won
    int pos;
    int rounds;
    int gl;
    int gr;
    bit mo;
    bit wp;
  } mdl_t;

  mdl_t m_a, m_b;

  always #5 clk = ~clk;

  tug_scorer_param #(.SIDE_DEPTH(3), .FAVOUR_LOSER(1), .MATCH_WINS(3)) dut_a (
    .clk(clk), .rst(rst), .winrnd(winrnd), .right(right), .leds_on(leds_on), .tie(tie),
    .fake(fake), .new_game(new_game), .score(score_a), .pos(pos_a), .game_over(go_a),
    .winner_right(wr_a), .win_pulse(wp_a), .rounds(rounds_a), .games_l(gl_a),
    .games_r(gr_a), .match_over(mo_a));

  tug_scorer_param #(.SIDE_DEPTH(5), .FAVOUR_LOSER(0), .MATCH_WINS(2)) dut_b (
    .clk(clk), .rst(rst), .winrnd(winrnd), .right(right), .leds_on(leds_on), .tie(tie),
    .fake(fake), .new_game(new_game), .score(score_b), .pos(pos_b), .game_over(go_b),
    .winner_right(wr_b), .win_pulse(wp_b), .rounds(rounds_b), .games_l(gl_b),
    .games_r(gr_b), .match_over(mo_b));

  function automatic mdl_t mnext(mdl_t m, int d, bit fav, int mw,
                                 bit r_rst, bit w, bit rt, bit l, bit t, bit f, bit ng);
    mdl_t n;
    bit valid, mr, lock;
    int np;
    n = m;
    n.wp = 1'b0;
    if (r_rst) begin
      n = '0;
      return n;
    end
    lock = 1'b0;
`ifdef TUG_MATCH_EN
    lock = m.mo;
`endif
    if (ng && !lock) begin
      n.st = 0; n.pos = 0; n.rounds = 0;
      return n;
    end
    if (m.st == 0 && w && !t) begin
      valid = l && !f;
      mr = valid ? rt : !rt;
      n.rounds = (m.rounds < 255) ? m.rounds + 1 : 255;
      if (mr && m.pos == d) begin
        n.st = 2; n.wp = 1'b1;
      end else if (!mr && m.pos == -d) begin
        n.st = 1; n.wp = 1'b1;
      end else begin
        np = mr ? m.pos + 1 : m.pos - 1;
        if (valid && fav && (m.pos >= 2 || m.pos <= -2) && ((mr && m.pos < 0) || (!mr && m.pos > 0)))
          np = (m.pos > 0) ? 1 : -1;
        n.pos = np;
      end
    end
`ifdef TUG_MATCH_EN
    if (n.wp && n.st == 2 && n.gr < 15) n.gr = n.gr + 1;
    if (n.wp && n.st == 1 && n.gl < 15) n.gl = n.gl + 1;
    if (n.gl >= mw || n.gr >= mw) n.mo = 1'b1;
`endif
    return n;
  endfunction

  function automatic int exp_score(mdl_t m, int d);
    case (m.st)
      0:       return 1 << (d - m.pos);
      1:       return ((1 << d) - 1) << (d + 1);
      default: return (1 << d) - 1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("a_score",  32'(score_a),  32'(exp_score(m_a, 3)));
    chk("a_pos",    32'(pos_a) & 32'hF, 32'(m_a.pos) & 32'hF);
    chk("a_over",   32'(go_a),     32'(m_a.st != 0));
    chk("a_winr",   32'(wr_a),     32'(m_a.st == 2));
    chk("a_pulse",  32'(wp_a),     32'(m_a.wp));
    chk("a_rounds", 32'(rounds_a), 32'(m_a.rounds));
    chk("a_gl",     32'(gl_a),     32'(m_a.gl));
    chk("a_gr",     32'(gr_a),     32'(m_a.gr));
    chk("a_match",  32'(mo_a),     32'(m_a.mo));
    chk("b_score",  32'(score_b),  32'(exp_score(m_b, 5)));
    chk("b_pos",    32'(pos_b) & 32'hF, 32'(m_b.pos) & 32'hF);
    chk("b_over",   32'(go_b),     32'(m_b.st != 0));
    chk("b_winr",   32'(wr_b),     32'(m_b.st == 2));
    chk("b_pulse",  32'(wp_b),     32'(m_b.wp));
    chk("b_rounds", 32'(rounds_b), 32'(m_b.rounds));
    chk("b_gl",     32'(gl_b),     32'(m_b.gl));
    chk("b_gr",     32'(gr_b),     32'(m_b.gr));
    chk("b_match",  32'(mo_b),     32'(m_b.mo));
  endtask

  task automatic tick(input bit r_rst, input bit w, input bit rt, input bit l,
                      input bit t, input bit f, input bit ng);
    rst = r_rst; winrnd = w; right = rt; leds_on = l; tie = t; fake = f; new_game = ng;
    @(posedge clk);
    m_a = mnext(m_a, 3, 1'b1, 3, r_rst, w, rt, l, t, f, ng);
    m_b = mnext(m_b, 5, 1'b0, 2, r_rst, w, rt, l, t, f, ng);
    #1;
    check_all();
    rst = 1'b0; winrnd = 1'b0; new_game = 1'b0;
  endtask

  initial begin
    rst = 1'b1; winrnd = 1'b0; right = 1'b0; leds_on = 1'b0;
    tie = 1'b0; fake = 1'b0; new_game = 1'b0;
    m_a = '0; m_b = '0;
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0);
    chk("rst_score_lit", 32'(score_a), 32'h08);

    // four valid right pushes: third lands on the edge, fourth wins
    for (int i = 0; i < 3; i++) tick(0, 1, 1, 1, 0, 0, 0);
    chk("edge_score_lit", 32'(score_a), 32'h01);
    tick(0, 1, 1, 1, 0, 0, 0);
    chk("win_score_lit", 32'(score_a), 32'h07);
    chk("win_rounds_lit", 32'(rounds_a), 32'd4);
    tick(0, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 1, 0, 0, 0);              // ignored in WIN_R
    tick(0, 1, 1, 1, 0, 0, 1);              // new_game beats winrnd
    chk("ng_pos_lit", 32'(pos_a) & 32'hF, 32'd0);

    // favour-the-loser snap from the right edge
    for (int i = 0; i < 3; i++) tick(0, 1, 1, 1, 0, 0, 0);
    tick(0, 1, 0, 1, 0, 0, 0);
    chk("snap_score_lit", 32'(score_a), 32'h04);
    chk("nosnap_pos_lit", 32'(pos_b) & 32'hF, 32'd2);

    tick(0, 0, 0, 0, 0, 0, 1);
    tick(0, 1, 1, 0, 0, 0, 0);              // jumped light penalises right
    chk("jump_score_lit", 32'(score_a), 32'h10);
    tick(0, 0, 0, 0, 0, 0, 1);
    tick(0, 1, 0, 1, 0, 1, 0);              // fake play penalises left
    chk("fake_score_lit", 32'(score_a), 32'h04);
    tick(0, 1, 1, 1, 1, 0, 0);              // tie: no move
    chk("tie_rounds_lit", 32'(rounds_a), 32'd1);

    // two right wins on the depth-5 instance close its match when enabled
    for (int g = 0; g < 2; g++) begin
      tick(0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 6; i++) tick(0, 1, 1, 1, 0, 0, 0);
    end
    tick(0, 0, 0, 0, 0, 0, 1);
`ifdef TUG_MATCH_EN
    chk("match_lock_lit", 32'(go_b), 32'd1);
`else
    chk("no_match_lit", 32'(mo_b), 32'd0);
`endif

    tick(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 19) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
